// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk cycles.
// Ports: clk, rst (async low), pwm_in -> high_time, period, valid, stuck, level.
module pwm_capture #(
  parameter int CTR_LEN     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CTR_LEN:0] high_time,
  output logic [CTR_LEN:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [CTR_LEN:0] MAX = '1;
  localparam logic [CTR_LEN:0] ONE = {{CTR_LEN{1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [CTR_LEN:0]       pcnt_q, pcnt_d;
  logic [CTR_LEN:0]       hcnt_q, hcnt_d;
  logic [CTR_LEN:0]       high_q, high_d;
  logic [CTR_LEN:0]       per_q, per_d;
  logic                   valid_q, valid_d;
  logic                   stuck_q, stuck_d;
  logic                   level_q, level_d;
  logic                   s;
  logic                   rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_prev_d = s;
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    high_d   = high_q;
    per_d    = per_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    level_d  = level_q;

    if (rise) begin
      pcnt_d  = ONE;
      hcnt_d  = ONE;
      stuck_d = 1'b0;
      state_d = MEAS;
      // first rise after IDLE only arms; partial period discarded
      if (state_q == MEAS) begin
        per_d   = pcnt_q;
        high_d  = hcnt_q;
        valid_d = 1'b1;
      end
    end else begin
      if (pcnt_q == MAX) begin
        // no edge within the window: flag and disarm, pcnt holds
        stuck_d = 1'b1;
        level_d = s;
        state_d = IDLE;
      end else begin
        pcnt_d = pcnt_q + ONE;
      end
      if (s && hcnt_q != MAX) begin
        hcnt_d = hcnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      high_q   <= '0;
      per_q    <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
      per_q    <= per_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign high_time = high_q;
  assign period    = per_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign level     = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture at default parameters.
// Drives PWM patterns, checks each valid result, stuck and reset behaviour.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [8:0] high_time;
  logic [8:0] period;
  logic       valid;
  logic       stuck;
  logic       level;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  bit          armed = 0;
  int          last_p = 0;
  int          last_h = 0;
  bit          valid_prev = 0;

  always #5 clk = ~clk;

  pwm_capture dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .high_time(high_time),
    .period(period),
    .valid(valid),
    .stuck(stuck),
    .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one PWM period starting with a rise; the previous period is
  // reported when this rise is seen, if the block was armed
  task automatic pulse(input int h, input int p);
    if (armed) begin
      exp_q.push_back({last_p[8:0], last_h[8:0]});
    end
    armed  = 1;
    last_p = p;
    last_h = h;
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
    if (p > 511) armed = 0;
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("no_back2back", {31'd0, valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {23'd0, period}, 32'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("period", {23'd0, period}, {23'd0, e[17:9]});
        chk("high_time", {23'd0, high_time}, {23'd0, e[8:0]});
      end
    end
    valid_prev = valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_high", {23'd0, high_time}, 0);
    chk("rst_period", {23'd0, period}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_stuck", {31'd0, stuck}, 0);
    chk("rst_level", {31'd0, level}, 0);
    rst = 1'b1;

    // dead-low input after reset
    repeat (500) @(negedge clk);
    chk("low_not_yet", {31'd0, stuck}, 0);
    repeat (30) @(negedge clk);
    chk("low_stuck", {31'd0, stuck}, 1);
    chk("low_level", {31'd0, level}, 0);

    // loopback-like 256-cycle periods, then compare change
    pulse(128, 256);
    chk("stuck_cleared", {31'd0, stuck}, 0);
    repeat (3) pulse(128, 256);
    repeat (3) pulse(30, 256);
    repeat (6) pulse(1, 2);
    pulse(200, 511);

    // hold high after a rise
    exp_q.push_back({last_p[8:0], last_h[8:0]});
    armed  = 0;
    pwm_in = 1'b1;
    repeat (530) @(negedge clk);
    chk("high_stuck", {31'd0, stuck}, 1);
    chk("high_level", {31'd0, level}, 1);
    chk("hold_period", {23'd0, period}, 511);
    chk("hold_high", {23'd0, high_time}, 200);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);

    pulse(5, 20);
    pulse(7, 20);
    pulse(3, 10);
    pulse(2, 6);

    // reset in the middle of a high phase
    exp_q.push_back({last_p[8:0], last_h[8:0]});
    pwm_in = 1'b1;
    repeat (6) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_high", {23'd0, high_time}, 0);
    chk("mid_rst_period", {23'd0, period}, 0);
    chk("mid_rst_valid", {31'd0, valid}, 0);
    chk("mid_rst_stuck", {31'd0, stuck}, 0);
    chk("mid_rst_level", {31'd0, level}, 0);
    chk("mid_rst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    armed  = 0;
    pwm_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    pulse(10, 40);
    pulse(20, 50);
    pulse(4, 9);
    repeat (10) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Measures an incoming PWM waveform and reports its high time and period in clock cycles.
- Is the receive-side counterpart of the team's counter/compare PWM generator. Used in loopback tests and to read back external PWM sources such as servo feedback and fan tach-style signals.
- Synchronizes the asynchronous input, times the interval between successive rising edges, and emits one result per period with a single-cycle valid strobe.
- Flags a stuck-high or stuck-low input once the period counter saturates.

## Interface

Parameters:
- `CTR_LEN`, default 8: width of the matching generator counter. Measurement counters are `CTR_LEN+1` bits wide, so a full generator period of 2^CTR_LEN fits.
- `SYNC_STAGES`, default 2: number of flops in the input synchronizer. Minimum 2.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserts immediately when low; logic runs when high.
- `pwm_in`, input, 1: PWM signal, asynchronous to `clk`.
- `high_time`, output, `CTR_LEN+1`: cycles `pwm_in` was high in the last completed period.
- `period`, output, `CTR_LEN+1`: cycles from one rising edge to the next.
- `valid`, output, 1: one-cycle strobe when `high_time` and `period` update.
- `stuck`, output, 1: no rising edge seen within the saturation window. Sticky.
- `level`, output, 1: synchronized input level captured when `stuck` asserted.

## Operation

- Synchronizer: a `SYNC_STAGES`-deep flop chain produces `s`. A register `s_d` holds the previous `s`. `rise = s & ~s_d`.
- Counters: `pcnt` and `hcnt`, each `CTR_LEN+1` bits. `MAX = 2^(CTR_LEN+1)-1`.
- States:
  - `IDLE`: not armed, no valid measurement in progress.
  - `MEAS`: counting a period.
- In every cycle with `rise`:
  - `pcnt <= 1`, `hcnt <= 1`.
  - `stuck <= 0`.
  - State goes to `MEAS`.
  - If the prior state was `MEAS`: `period <= pcnt`, `high_time <= hcnt`, `valid <= 1`.
  - If the prior state was `IDLE`: the rise only arms the block. `valid` stays 0, because the partial first period is discarded.
- In a cycle without `rise`:
  - `pcnt` increments, saturating at `MAX`.
  - `hcnt` increments only when `s == 1`, saturating at `MAX`.
- Saturation: if `pcnt == MAX` and there is no `rise` in that cycle:
  - `stuck <= 1`, `level <= s`.
  - State goes to `IDLE`, with no `valid`.
  - `pcnt` holds at `MAX`; it never wraps.
  - This applies in both states, so a dead input after reset is also flagged.
- Simultaneous `rise` and `pcnt == MAX`: the rise wins. `valid` pulses with `period = MAX`.
- `high_time` and `period` hold their last values between strobes, and are not cleared by `stuck`.
- Against the generator at `CTR_LEN = 8`: `period = 256` and `high_time = compare`. Setting `compare = 0` yields `stuck = 1` with `level = 0`.

## Timing

- Reset (`rst` low, asynchronous) forces:
  - `high_time = 0`, `period = 0`, `valid = 0`, `stuck = 0`, `level = 0`.
  - State `IDLE`.
  - Synchronizer flops, `s_d`, `pcnt` and `hcnt` all 0.
- Reset mid-period discards the partial measurement. The first rise after release only arms the block.
- Latency: if a `pwm_in` rising edge is first sampled at clock edge N, then `valid` is high from edge N+`SYNC_STAGES` to edge N+`SYNC_STAGES`+1. Because the delay is constant, the measured widths are unaffected.
- `valid` is never high for two consecutive cycles, because the minimum measurable period is 2.
- `stuck` asserts on the clock edge where `pcnt` would exceed `MAX`. At default parameters this is 511 cycles after the last rise.
- Pulses narrower than one clock can be missed. No glitch filtering is performed.

## Test plan

- Loopback from the generator (`CTR_LEN = 8`, `compare = 128`): the first rise gives no `valid`. Every following `valid` shows `period = 256` and `high_time = 128`, with strobes exactly 256 cycles apart.
- Switch `compare` from 128 to 30 mid-run: at most one transitional result, then every result is `period = 256`, `high_time = 30`.
- Hold `pwm_in` low from reset release: no `valid`; `stuck = 1` and `level = 0` after 511 cycles. A later rise clears `stuck` and only arms the block; the next rise produces a `valid`.
- Hold `pwm_in` high after one rise: after 511 cycles `stuck = 1`, `level = 1`, `high_time` and `period` keep their last values, and state is `IDLE`.
- Toggle `pwm_in` every clock (1 high, 1 low): `valid` every 2 cycles with `period = 2`, `high_time = 1`. Also drive a 511-cycle period: `valid` with `period = 511` and `stuck` stays 0.
- Assert `rst` low mid-period at a non-edge time: all outputs are 0 immediately. After release, the first rise gives no `valid` and the second gives correct values.
